// File: rtl/join_pkg.sv
// rtl/join_pkg.sv - shared JoinCore window-tuple layout helpers and injector state encoding
//
// Window tuple layout: [WIDTH-1] valid, [127:64] ts, [63:32] des, [31:0] src.
package join_pkg;

    localparam int PARA_WINDOW_TUPLE_WIDTH = 129;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } inj_state_e;

    function automatic int wt_valid_bit(input int width);
        return width - 1;
    endfunction

    function automatic logic [31:0] wt_src(input logic [127:0] p);
        return p[31:0];
    endfunction

    function automatic logic [31:0] wt_des(input logic [127:0] p);
        return p[63:32];
    endfunction

    function automatic logic [63:0] wt_ts(input logic [127:0] p);
        return p[127:64];
    endfunction

    function automatic logic [127:0] wt_payload(input logic [63:0] ts, input logic [31:0] des,
                                                input logic [31:0] src);
        return {ts, des, src};
    endfunction

endpackage

// File: rtl/tuple_skid_buffer.sv
// rtl/tuple_skid_buffer.sv - 2-entry valid/ready buffer with fall-through when empty
//
// Ports:
//   aclk, aresetn        clock, synchronous active-low reset
//   s_tdata, s_tvalid    write side; s_tvalid is an already-accepted beat (caller honours level)
//   m_tdata, m_tvalid    read side; shows the head entry, or the incoming beat when empty
//   m_tready             read side ready; a pop happens on m_tvalid & m_tready
//   level, level_next    occupancy now and after the coming edge (0..2)
module tuple_skid_buffer #(
    parameter int WIDTH = 128
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic [WIDTH-1:0] s_tdata,
    input  logic             s_tvalid,
    output logic [WIDTH-1:0] m_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic [1:0]       level,
    output logic [1:0]       level_next
);

    logic [WIDTH-1:0] mem0_q, mem0_d;
    logic [WIDTH-1:0] mem1_q, mem1_d;
    logic [1:0]       level_q, level_d;
    logic             pop;

    // When empty, the incoming beat is presented straight through so it can
    // reach the consumer in the same cycle it is accepted.
    assign m_tvalid   = (level_q != 2'd0) | s_tvalid;
    assign m_tdata    = (level_q != 2'd0) ? mem0_q : s_tdata;
    assign pop        = m_tvalid & m_tready;
    assign level      = level_q;
    assign level_next = level_d;

    always_comb begin
        mem0_d  = mem0_q;
        mem1_d  = mem1_q;
        level_d = level_q;
        case (level_q)
            2'd0: begin
                if (s_tvalid && !pop) begin
                    mem0_d  = s_tdata;
                    level_d = 2'd1;
                end
            end
            2'd1: begin
                if (s_tvalid && pop) begin
                    mem0_d = s_tdata;
                end else if (s_tvalid) begin
                    mem1_d  = s_tdata;
                    level_d = 2'd2;
                end else if (pop) begin
                    level_d = 2'd0;
                end
            end
            2'd2: begin
                if (pop) begin
                    mem0_d  = mem1_q;
                    level_d = 2'd1;
                    if (s_tvalid) begin
                        mem1_d  = s_tdata;
                        level_d = 2'd2;
                    end
                end
            end
            default: level_d = 2'd0;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            mem0_q  <= '0;
            mem1_q  <= '0;
            level_q <= 2'd0;
        end else begin
            mem0_q  <= mem0_d;
            mem1_q  <= mem1_d;
            level_q <= level_d;
        end
    end

endmodule

// File: rtl/window_tuple_injector.sv
// rtl/window_tuple_injector.sv - AXIS-to-stage-0 window tuple injector with batch control
//
// Ports:
//   aclk, aresetn                 clock, synchronous active-low reset
//   start, tuple_total            batch start pulse and tuple count (sampled in IDLE)
//   s_axis_t{data,valid,ready,last}  upstream tuple payload stream
//   window_tuple_output           registered tuple {valid, payload} to stage 0
//   window_stage_full_input       stage-0 full flag; blocks transfers
//   inject_count, busy, done, short_batch  batch status
module window_tuple_injector
    import join_pkg::*;
#(
    parameter int WINDOW_TUPLE_WIDTH = PARA_WINDOW_TUPLE_WIDTH,
    parameter int COUNT_WIDTH        = 32
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic                          start,
    input  logic [COUNT_WIDTH-1:0]        tuple_total,
    input  logic [WINDOW_TUPLE_WIDTH-2:0] s_axis_tdata,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic                          s_axis_tlast,
    output logic [WINDOW_TUPLE_WIDTH-1:0] window_tuple_output,
    input  logic                          window_stage_full_input,
    output logic [COUNT_WIDTH-1:0]        inject_count,
    output logic                          busy,
    output logic                          done,
    output logic                          short_batch
);

    localparam int VB = wt_valid_bit(WINDOW_TUPLE_WIDTH);
    localparam int PW = WINDOW_TUPLE_WIDTH - 1;

    inj_state_e                    state_q, state_d;
    logic [COUNT_WIDTH-1:0]        total_q, total_d;
    logic [COUNT_WIDTH-1:0]        accepted_q, accepted_d;
    logic [COUNT_WIDTH-1:0]        inject_q, inject_d;
    logic                          tlast_seen_q, tlast_seen_d;
    logic                          short_q, short_d;
    logic                          tready_q, tready_d;
    logic                          busy_q, busy_d;
    logic                          done_q, done_d;
    logic [WINDOW_TUPLE_WIDTH-1:0] out_q, out_d;

    logic          accept;
    logic          xfer;
    logic          out_load;
    logic [PW-1:0] buf_tdata;
    logic          buf_tvalid;
    logic [1:0]    buf_level;
    logic [1:0]    buf_level_next;

    assign accept   = s_axis_tvalid & tready_q;
    assign xfer     = out_q[VB] & ~window_stage_full_input;
    // Output register may take a new tuple when empty or handing its tuple over.
    assign out_load = ~out_q[VB] | xfer;

    tuple_skid_buffer #(
        .WIDTH(PW)
    ) u_skid (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .s_tdata    (s_axis_tdata),
        .s_tvalid   (accept),
        .m_tdata    (buf_tdata),
        .m_tvalid   (buf_tvalid),
        .m_tready   (out_load),
        .level      (buf_level),
        .level_next (buf_level_next)
    );

    always_comb begin
        state_d      = state_q;
        total_d      = total_q;
        accepted_d   = accepted_q;
        inject_d     = inject_q;
        tlast_seen_d = tlast_seen_q;
        short_d      = short_q;
        out_d        = out_q;

        if (out_load) begin
            out_d = buf_tvalid ? {1'b1, buf_tdata} : '0;
        end
        // Saturate at the programmed total so the count can never wrap.
        if (xfer && (inject_q != total_q)) begin
            inject_d = inject_q + COUNT_WIDTH'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    total_d      = tuple_total;
                    accepted_d   = '0;
                    inject_d     = '0;
                    tlast_seen_d = 1'b0;
                    short_d      = 1'b0;
                    state_d      = (tuple_total == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    accepted_d = accepted_q + COUNT_WIDTH'(1);
                    if (s_axis_tlast) begin
                        tlast_seen_d = 1'b1;
                        short_d      = ({1'b0, accepted_q} + (COUNT_WIDTH + 1)'(1)) < {1'b0, total_q};
                        state_d      = ST_DRAIN;
                    end else if (accepted_d == total_q) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if ((buf_level == 2'd0) && !out_q[VB]) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Ready is registered from the post-edge buffer level, so a beat is never
    // offered room that the coming edge has already filled.
    assign tready_d = (state_d == ST_RUN) && (buf_level_next != 2'd2) &&
                      (accepted_d < total_d) && !tlast_seen_d;
    assign busy_d   = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    assign done_d   = (state_d == ST_DONE);

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q      <= ST_IDLE;
            total_q      <= '0;
            accepted_q   <= '0;
            inject_q     <= '0;
            tlast_seen_q <= 1'b0;
            short_q      <= 1'b0;
            tready_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            out_q        <= '0;
        end else begin
            state_q      <= state_d;
            total_q      <= total_d;
            accepted_q   <= accepted_d;
            inject_q     <= inject_d;
            tlast_seen_q <= tlast_seen_d;
            short_q      <= short_d;
            tready_q     <= tready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            out_q        <= out_d;
        end
    end

    assign s_axis_tready       = tready_q;
    assign window_tuple_output = out_q;
    assign inject_count        = inject_q;
    assign busy                = busy_q;
    assign done                = done_q;
    assign short_batch         = short_q;

endmodule

// File: tb/tb_window_tuple_injector.sv
// tb/tb_window_tuple_injector.sv - self-checking bench for window_tuple_injector
module tb_window_tuple_injector;
    import join_pkg::*;

    localparam int W  = 129;
    localparam int CW = 32;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic          start;
    logic [CW-1:0] tuple_total;
    logic [W-2:0]  s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic          s_axis_tlast;
    logic [W-1:0]  window_tuple_output;
    logic          window_stage_full_input;
    logic [CW-1:0] inject_count;
    logic          busy;
    logic          done;
    logic          short_batch;

    always #5 aclk = ~aclk;

    window_tuple_injector #(
        .WINDOW_TUPLE_WIDTH(W),
        .COUNT_WIDTH(CW)
    ) dut (
        .aclk                    (aclk),
        .aresetn                 (aresetn),
        .start                   (start),
        .tuple_total             (tuple_total),
        .s_axis_tdata            (s_axis_tdata),
        .s_axis_tvalid           (s_axis_tvalid),
        .s_axis_tready           (s_axis_tready),
        .s_axis_tlast            (s_axis_tlast),
        .window_tuple_output     (window_tuple_output),
        .window_stage_full_input (window_stage_full_input),
        .inject_count            (inject_count),
        .busy                    (busy),
        .done                    (done),
        .short_batch             (short_batch)
    );

    int tests = 0;
    int fails = 0;

    logic [W-2:0] src_q[$];
    logic [W-2:0] got_q[$];
    int done_cnt, tready_hi, accepted_n, stall_viol, stall_acc, first_x, last_x;
    bit tr_hist[512];

    task automatic gen_src(input int n);
        src_q.delete();
        for (int i = 0; i < n; i++) begin
            src_q.push_back(wt_payload({$urandom, $urandom}, $urandom, $urandom));
        end
    endtask

    // Index of first disagreement between observed transfers and the first n source beats, -1 if none.
    function automatic int first_diff(input int n);
        for (int i = 0; i < n; i++) begin
            if (i >= got_q.size() || got_q[i] !== src_q[i]) return i;
        end
        if (got_q.size() != n) return n;
        return -1;
    endfunction

    // Stimulus driver and observer for one batch. stall_mode: 0 never full,
    // 1 full on cycles 3..7, 2 full on odd cycles, 3 random full and tvalid gaps.
    task automatic run_batch(input int total, input int tlast_at, input int stall_mode,
                             input int reset_after);
        int beat = 0;
        int cyc = 0;
        bit acc, xfer, prev_full;
        logic [W-1:0] prev_out;
        got_q.delete();
        done_cnt = 0; tready_hi = 0; accepted_n = 0; stall_viol = 0; stall_acc = 0;
        first_x = -1; last_x = -1;
        prev_full = 1'b0; prev_out = '0;
        for (int i = 0; i < 512; i++) tr_hist[i] = 1'b0;
        s_axis_tvalid = 1'b0; window_stage_full_input = 1'b0;
        start = 1'b1; tuple_total = CW'(total);
        @(posedge aclk); #1;
        start = 1'b0;
        forever begin
            if (cyc > 0 && prev_full && window_tuple_output !== prev_out) stall_viol++;
            if (done) done_cnt++;
            if (done_cnt > 0 && !done) break;
            if (reset_after >= 0 && got_q.size() == reset_after) break;
            if (cyc >= 400) break;
            s_axis_tvalid = (beat < src_q.size()) && (stall_mode != 3 || $urandom_range(0, 3) != 0);
            s_axis_tdata  = (beat < src_q.size()) ? src_q[beat] : '0;
            s_axis_tlast  = (beat == tlast_at);
            case (stall_mode)
                1:       window_stage_full_input = (cyc >= 3 && cyc < 8);
                2:       window_stage_full_input = (cyc % 2) == 1;
                3:       window_stage_full_input = ($urandom_range(0, 2) == 0);
                default: window_stage_full_input = 1'b0;
            endcase
            tr_hist[cyc] = s_axis_tready;
            if (s_axis_tready) tready_hi++;
            acc  = s_axis_tvalid && s_axis_tready;
            xfer = window_tuple_output[W-1] && !window_stage_full_input;
            if (xfer) begin
                got_q.push_back(window_tuple_output[W-2:0]);
                if (first_x < 0) first_x = cyc;
                last_x = cyc;
            end
            if (acc) begin
                beat++;
                accepted_n++;
                if (window_stage_full_input) stall_acc++;
            end
            prev_full = window_stage_full_input;
            prev_out  = window_tuple_output;
            @(posedge aclk); #1;
            cyc++;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        window_stage_full_input = 1'b0;
    endtask

    task automatic test_reset();
        aresetn = 1'b0; start = 1'b0; s_axis_tvalid = 1'b1; s_axis_tlast = 1'b0;
        s_axis_tdata = '1; window_stage_full_input = 1'b0; tuple_total = 32'd5;
        repeat (2) @(posedge aclk);
        #1;
        tests++; if (window_tuple_output !== '0) begin fails++; $display("FAIL reset_out got=%h exp=0", window_tuple_output); end
        tests++; if (s_axis_tready !== 1'b0) begin fails++; $display("FAIL reset_tready got=%b exp=0", s_axis_tready); end
        tests++; if ({busy, done, short_batch} !== 3'b000) begin fails++; $display("FAIL reset_flags got=%b exp=000", {busy, done, short_batch}); end
        tests++; if (inject_count !== '0) begin fails++; $display("FAIL reset_count got=%0d exp=0", inject_count); end
        aresetn = 1'b1; s_axis_tvalid = 1'b0;
        @(posedge aclk); #1;
    endtask

    task automatic test_streaming();
        int d;
        gen_src(4);
        run_batch(4, -1, 0, -1);
        d = first_diff(4);
        tests++; if (d != -1) begin fails++; $display("FAIL stream_order idx=%0d got_n=%0d exp_n=4", d, got_q.size()); end
        tests++; if (last_x - first_x != 3) begin fails++; $display("FAIL stream_back_to_back span=%0d exp=3", last_x - first_x); end
        tests++; if (inject_count !== 32'd4) begin fails++; $display("FAIL stream_count got=%0d exp=4", inject_count); end
        tests++; if (done_cnt != 1) begin fails++; $display("FAIL stream_done got=%0d exp=1", done_cnt); end
        tests++; if (short_batch !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL stream_flags got=%b%b exp=00", short_batch, busy); end
    endtask

    task automatic test_stall();
        int d;
        gen_src(8);
        run_batch(8, -1, 1, -1);
        d = first_diff(8);
        tests++; if (d != -1) begin fails++; $display("FAIL stall_order idx=%0d got_n=%0d exp_n=8", d, got_q.size()); end
        tests++; if (stall_viol != 0) begin fails++; $display("FAIL stall_hold changes=%0d exp=0", stall_viol); end
        tests++; if (stall_acc != 2) begin fails++; $display("FAIL stall_buffer_fill got=%0d exp=2", stall_acc); end
        tests++; if (tr_hist[7] !== 1'b0) begin fails++; $display("FAIL stall_tready got=%b exp=0", tr_hist[7]); end
        tests++; if (inject_count !== 32'd8) begin fails++; $display("FAIL stall_count got=%0d exp=8", inject_count); end
    endtask

    task automatic test_early_tlast();
        int d;
        gen_src(8);
        run_batch(8, 2, 0, -1);
        d = first_diff(3);
        tests++; if (d != -1) begin fails++; $display("FAIL tlast_order idx=%0d got_n=%0d exp_n=3", d, got_q.size()); end
        tests++; if (accepted_n != 3) begin fails++; $display("FAIL tlast_accepted got=%0d exp=3", accepted_n); end
        tests++; if (inject_count !== 32'd3) begin fails++; $display("FAIL tlast_count got=%0d exp=3", inject_count); end
        tests++; if (short_batch !== 1'b1) begin fails++; $display("FAIL tlast_short got=%b exp=1", short_batch); end
        tests++; if (done_cnt != 1) begin fails++; $display("FAIL tlast_done got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_zero_length();
        gen_src(4);
        run_batch(0, -1, 0, -1);
        tests++; if (tready_hi != 0) begin fails++; $display("FAIL zero_tready high_cycles=%0d exp=0", tready_hi); end
        tests++; if (got_q.size() != 0) begin fails++; $display("FAIL zero_output got_n=%0d exp=0", got_q.size()); end
        tests++; if (done_cnt != 1) begin fails++; $display("FAIL zero_done got=%0d exp=1", done_cnt); end
        tests++; if (short_batch !== 1'b0) begin fails++; $display("FAIL zero_short got=%b exp=0", short_batch); end
    endtask

    task automatic test_reset_mid();
        int d;
        gen_src(6);
        run_batch(6, -1, 0, 2);
        aresetn = 1'b0;
        @(posedge aclk); #1;
        tests++; if (window_tuple_output !== '0 || s_axis_tready !== 1'b0) begin fails++; $display("FAIL midreset_out got=%h/%b exp=0/0", window_tuple_output, s_axis_tready); end
        tests++; if ({busy, done, short_batch} !== 3'b000 || inject_count !== '0) begin fails++; $display("FAIL midreset_status got=%b/%0d exp=000/0", {busy, done, short_batch}, inject_count); end
        aresetn = 1'b1;
        @(posedge aclk); #1;
        gen_src(6);
        run_batch(6, -1, 0, -1);
        d = first_diff(6);
        tests++; if (d != -1) begin fails++; $display("FAIL restart_order idx=%0d got_n=%0d exp_n=6", d, got_q.size()); end
        tests++; if (inject_count !== 32'd6) begin fails++; $display("FAIL restart_count got=%0d exp=6", inject_count); end
    endtask

    task automatic test_toggle();
        int d;
        gen_src(10);
        run_batch(10, -1, 2, -1);
        d = first_diff(10);
        tests++; if (d != -1) begin fails++; $display("FAIL toggle_order idx=%0d got_n=%0d exp_n=10", d, got_q.size()); end
        tests++; if (inject_count !== CW'(got_q.size())) begin fails++; $display("FAIL toggle_count got=%0d exp=%0d", inject_count, got_q.size()); end
        tests++; if (done_cnt != 1) begin fails++; $display("FAIL toggle_done got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_random();
        int total, tl, exp_n, d;
        bit exp_short;
        for (int k = 0; k < 8; k++) begin
            total = $urandom_range(1, 10);
            tl = ($urandom_range(0, 1) == 1) ? $urandom_range(0, total - 1) : -1;
            exp_n = (tl < 0) ? total : tl + 1;
            exp_short = (tl >= 0) && (tl + 1 < total);
            gen_src(total + 2);
            run_batch(total, tl, 3, -1);
            d = first_diff(exp_n);
            tests++; if (d != -1) begin fails++; $display("FAIL rand%0d_order idx=%0d got_n=%0d exp_n=%0d", k, d, got_q.size(), exp_n); end
            tests++; if (accepted_n != exp_n) begin fails++; $display("FAIL rand%0d_accepted got=%0d exp=%0d", k, accepted_n, exp_n); end
            tests++; if (inject_count !== CW'(exp_n)) begin fails++; $display("FAIL rand%0d_count got=%0d exp=%0d", k, inject_count, exp_n); end
            tests++; if (short_batch !== exp_short) begin fails++; $display("FAIL rand%0d_short got=%b exp=%b", k, short_batch, exp_short); end
            tests++; if (done_cnt != 1) begin fails++; $display("FAIL rand%0d_done got=%0d exp=1", k, done_cnt); end
        end
    endtask

    initial begin
        aresetn = 1'b0; start = 1'b0; tuple_total = '0; s_axis_tdata = '0;
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; window_stage_full_input = 1'b0;
        test_reset();
        test_streaming();
        test_stall();
        test_early_tlast();
        test_zero_length();
        test_reset_mid();
        test_toggle();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/window_tuple_injector.md
# window_tuple_injector

Feeds window tuples into the head of the JoinCore systolic chain. Accepts 128-bit tuple payloads from an upstream AXI4-Stream slave port, tags them with the window-tuple valid bit, and drives stage 0's window tuple input. It honours stage 0's full flag and terminates a batch after a programmed count or on `tlast`. It is the transmitter for the stage-0 window-tuple input and sits between the window loader and the first join stage.

## Interface
- `WINDOW_TUPLE_WIDTH`, default `PARA_WINDOW_TUPLE_WIDTH` (129): window tuple width. Bit MSB is the valid bit; bits [127:0] are the payload (`src` 31:0, `des` 63:32, `ts` 127:64).
- `COUNT_WIDTH`, default 32: width of the batch counters.

- `aclk`  in  1  kernel clock; all logic on the rising edge.
- `aresetn`  in  1  synchronous, active-low reset.
- `start`  in  1  one-cycle pulse that begins a batch; ignored unless in IDLE.
- `tuple_total`  in  COUNT_WIDTH  number of tuples in the batch; sampled when `start` is accepted.
- `s_axis_tdata`  in  WINDOW_TUPLE_WIDTH-1  tuple payload.
- `s_axis_tvalid`  in  1  upstream valid.
- `s_axis_tready`  out  1  upstream ready; driven from a register.
- `s_axis_tlast`  in  1  last tuple of the source stream.
- `window_tuple_output`  out  WINDOW_TUPLE_WIDTH  connects to stage-0 `window_tuple_input`.
- `window_stage_full_input`  in  1  connects to stage-0 `window_stage_full_output`.
- `inject_count`  out  COUNT_WIDTH  number of tuples consumed by stage 0 in the current or last batch.
- `busy`  out  1  high in RUN or DRAIN.
- `done`  out  1  one-cycle pulse at batch end.
- `short_batch`  out  1  `tlast` ended the batch before `tuple_total`; held until the next `start`.

## Operation
- **Output transfer rule.** A transfer to stage 0 occurs in a cycle where `window_tuple_output` MSB=1 and `window_stage_full_input`=0. Stage 0 latches the tuple on that edge.
- **Output register.** `window_tuple_output` is a register. After a transfer it either loads the next buffered tuple or clears to all-zero (an idle bubble). Payload bits are don't-care whenever the MSB is 0, but are driven to 0.
- **Skid buffer.** A 2-entry buffer sits between the AXIS port and the output register.
  - `s_axis_tready` = (state==RUN) & (buffer not full) & (accepted < total) & !tlast_seen.
  - An AXIS beat is accepted when `s_axis_tvalid` and `s_axis_tready` are both high.
- **State machine** (IDLE, RUN, DRAIN, DONE):
  - IDLE: on `start`, latch `tuple_total`, clear `inject_count`, `accepted`, `tlast_seen` and `short_batch`. If `tuple_total`==0, go directly to DONE; otherwise go to RUN.
  - RUN: accept beats. Go to DRAIN when `accepted` reaches `tuple_total`, or on acceptance of a beat with `tlast`=1. In the `tlast` case, set `short_batch`=1 if `accepted`+1 < `tuple_total`.
  - DRAIN: `s_axis_tready`=0. Keep injecting until the buffer is empty and the output MSB is 0, then go to DONE.
  - DONE: `done`=1 for exactly one cycle, then go to IDLE.
- **Counter.** `inject_count` increments on every transfer to stage 0. It never exceeds `tuple_total`; the counter saturates and must not wrap.
- **Simultaneous events.** In a single cycle, transfer-out and AXIS-accept may both occur; buffer occupancy is unchanged.
- **Stall.** While `window_stage_full_input`=1, the output register holds its value and the buffer fills. `tready` drops once the buffer is full.
- **Reset.** `aresetn`=0 at any point, including mid-batch, forces:
  - state to IDLE and the buffer empty;
  - `window_tuple_output`=0, `s_axis_tready`=0, `busy`=0, `done`=0, `short_batch`=0, `inject_count`=0.
  - In-flight tuples are discarded.

## Timing
- Latency from AXIS accept to `window_tuple_output` valid is 1 cycle when the buffer is empty and the output register is empty or transferring.
- Sustained throughput is 1 tuple/cycle while stage 0 is never full.
- `s_axis_tready` reflects buffer state registered at the previous edge, so it rises 1 cycle after space frees.
- `done` asserts 1 cycle after the final transfer, because the output register must first clear to 0.
- `start` in any state other than IDLE is ignored.

## Structure
- Shared package `join_pkg`:
  - field slices `_src`, `_des`, `_ts`;
  - valid-bit index `WINDOW_TUPLE_WIDTH-1`;
  - state encoding constants.
- Sub-module `tuple_skid_buffer`: a 2-entry valid/ready buffer parameterised on width. It is reused later for result-pair output.
- The FSM and counters live in the top module.

## Test plan
- **Streaming, no stall:** `tuple_total`=4, 4 back-to-back beats, stage never full. Expect 4 consecutive outputs with MSB=1 and payloads matching, `inject_count`=4, `done` pulse, `short_batch`=0.
- **Stage stall:** full held high for 5 cycles mid-stream. Expect output held constant, `s_axis_tready`=0 after the buffer reaches 2, no tuple lost or duplicated, order preserved.
- **Early `tlast`:** `tuple_total`=8, `tlast` on beat 3. Expect 3 tuples injected, `short_batch`=1, `done` pulse, `tready`=0 after beat 3.
- **Zero-length batch:** `tuple_total`=0. Expect `done` 1 cycle after entering DONE, no output valid, `tready` never high.
- **Reset mid-batch:** `aresetn`=0 for 1 cycle after 2 of 6 tuples. Expect all outputs 0 on the next edge and a clean restart on a new `start` with `inject_count` from 0.
- **Simultaneous in/out:** `tvalid` held high with stage full toggling every cycle. Expect `inject_count` to equal the number of cycles with full=0 and output MSB=1, and payloads in sequence.
